// File: rtl/divider.sv
// ---------------------------------------------------------------------------
// divider : sequential restoring shift-subtract divider, 32-bit operands.
//
// One quotient bit is produced per clock, MSB first, over 32 CALC cycles.
// Build option: define DIVIDER_SIGNED_EN for two's-complement signed division
// (magnitudes are divided, quotient truncates toward zero, remainder takes the
// dividend's sign). Latency and handshake are the same in both builds.
//
// Ports:
//   clk          clock, all state updates on the rising edge
//   rst_n        asynchronous active-low reset
//   start        begin a division (accepted only while busy == 0)
//   A, B         dividend / divisor, captured on the accepting edge
//   busy         high for the 32 iteration cycles
//   done         one-cycle pulse when quotient/remainder/div_by_zero update
//   quotient     result of the last completed operation
//   remainder    remainder of the last completed operation
//   div_by_zero  last completed operation had B == 0
// ---------------------------------------------------------------------------
module divider (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        div_by_zero
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t      state;
  logic [31:0] a_reg;     // original dividend, needed for the B == 0 result
  logic [31:0] b_reg;     // divisor magnitude
  logic [31:0] q_reg;     // dividend bits shift out at the top, quotient bits in at the bottom
  logic [32:0] rem_reg;   // partial remainder, one spare bit for the trial subtraction
  logic [4:0]  count;
`ifdef DIVIDER_SIGNED_EN
  logic        b_neg;
`endif

  // One restoring iteration.
  logic [33:0] shifted;
  logic [33:0] diff;
  logic        qbit;
  logic [32:0] rem_next;
  logic [31:0] q_next;
  logic [31:0] q_res;
  logic [31:0] r_res;
  logic        b_zero;

  always_comb begin
    shifted  = {rem_reg, q_reg[31]};
    diff     = shifted - {2'b00, b_reg};
    qbit     = ~diff[33];               // no borrow: divisor fits
    rem_next = qbit ? diff[32:0] : shifted[32:0];
    q_next   = {q_reg[30:0], qbit};
    b_zero   = (b_reg == 32'd0);
`ifdef DIVIDER_SIGNED_EN
    q_res = (a_reg[31] ^ b_neg) ? (32'd0 - q_next) : q_next;
    r_res = a_reg[31] ? (32'd0 - rem_next[31:0]) : rem_next[31:0];
`else
    q_res = q_next;
    r_res = rem_next[31:0];
`endif
    if (b_zero) begin
      q_res = 32'hFFFF_FFFF;
      r_res = a_reg;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= 32'd0;
      remainder   <= 32'd0;
      div_by_zero <= 1'b0;
      a_reg       <= 32'd0;
      b_reg       <= 32'd0;
      q_reg       <= 32'd0;
      rem_reg     <= 33'd0;
      count       <= 5'd0;
`ifdef DIVIDER_SIGNED_EN
      b_neg       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            a_reg   <= A;
            rem_reg <= 33'd0;
            count   <= 5'd0;
            busy    <= 1'b1;
            state   <= CALC;
`ifdef DIVIDER_SIGNED_EN
            b_neg   <= B[31];
            b_reg   <= B[31] ? (32'd0 - B) : B;
            q_reg   <= A[31] ? (32'd0 - A) : A;
`else
            b_reg   <= B;
            q_reg   <= A;
`endif
          end else begin
            state <= IDLE;
          end
        end
        CALC: begin
          q_reg   <= q_next;
          rem_reg <= rem_next;
          count   <= count + 5'd1;
          if (count == 5'd31) begin
            quotient    <= q_res;
            remainder   <= r_res;
            div_by_zero <= b_zero;
            done        <= 1'b1;
            busy        <= 1'b0;
            state       <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/divider.md
DIVIDER -- requirements
Module: divider

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 rst_n  input  1  asynchronous, active-low reset; clears all state immediately on assertion, independent of clk.
REQ-003 start  input  1  request to begin a division; sampled on rising clk.
REQ-004 A  input  32  dividend; captured on the edge that accepts start.
REQ-005 B  input  32  divisor; captured on the edge that accepts start.
REQ-006 busy  output  1  high while an iteration sequence is in progress.
REQ-007 done  output  1  single-cycle pulse marking new valid results.
REQ-008 quotient  output  32  registered quotient of the last completed operation.
REQ-009 remainder  output  32  registered remainder of the last completed operation.
REQ-010 div_by_zero  output  1  registered flag: last completed operation had B == 0.

Function
REQ-011 Block SHALL be a sequential restoring shift-subtract divider: one quotient bit per clk, 32 iteration cycles, MSB first.
REQ-012 States SHALL be IDLE, CALC, DONE; IDLE->CALC on accepted start; CALC->DONE after the 32nd iteration; DONE->IDLE after one cycle unless start is accepted (DONE->CALC).
REQ-013 start SHALL be accepted only when busy == 0 (IDLE or DONE); start while busy SHALL be ignored with no effect on the operation in flight.
REQ-014 On acceptance at edge k, A and B SHALL be captured internally; later changes to A/B SHALL not affect the result.
REQ-015 busy SHALL be 1 from edge k through edge k+32 (32 cycles), 0 otherwise.
REQ-016 At edge k+32, quotient, remainder, div_by_zero SHALL update together and done SHALL be 1 for exactly the cycle between edges k+32 and k+33.
REQ-017 quotient, remainder, div_by_zero SHALL hold their values between completions, including throughout a following CALC.
REQ-018 Partial remainder SHALL be 33 bits wide to hold the trial-subtraction borrow; no intermediate truncation.
REQ-019 Unsigned result SHALL satisfy A == quotient*B + remainder with remainder < B for B != 0.
REQ-020 B == 0 SHALL produce quotient = 32'hFFFFFFFF, remainder = A, div_by_zero = 1, with the normal 32-cycle latency.
REQ-021 Start accepted in DONE SHALL behave identically to start accepted in IDLE; done SHALL deassert next cycle.

Reset
REQ-022 rst_n low SHALL force state IDLE, busy 0, done 0, quotient 0, remainder 0, div_by_zero 0, iteration counter 0, internal operand registers 0.
REQ-023 Reset asserted mid-CALC SHALL abort the operation; no done pulse and no result update SHALL follow reset release.
REQ-024 First start SHALL be accepted on the first rising clk edge with rst_n high.

Configuration
REQ-025 Macro DIVIDER_SIGNED_EN SHALL select two's-complement signed division when defined; undefined SHALL give unsigned division per REQ-019.
REQ-026 Signed mode: divide magnitudes, quotient truncates toward zero, quotient negated when operand signs differ, remainder takes dividend's sign.
REQ-027 Signed mode: B == 0 SHALL give quotient = 32'hFFFFFFFF, remainder = A, div_by_zero = 1.
REQ-028 Signed mode: A = 32'h80000000, B = 32'hFFFFFFFF SHALL give quotient = 32'h80000000, remainder = 0, div_by_zero = 0.
REQ-029 Latency and handshake SHALL be identical in both configurations.

Verification
REQ-030 A=100, B=7, start at edge k -> busy 32 cycles; done at k+32; quotient=14, remainder=2, div_by_zero=0.
REQ-031 A=32'hFFFFFFFF, B=1 (unsigned) -> quotient=32'hFFFFFFFF, remainder=0; A=5, B=0 -> quotient=32'hFFFFFFFF, remainder=5, div_by_zero=1.
REQ-032 start pulsed at k+10 with A=9,B=3 during A=100,B=7 op -> ignored; result 14/2 at k+32; no second done.
REQ-033 rst_n low at k+15 for one cycle -> all outputs 0 immediately; no done afterwards; new start A=20,B=6 after release -> quotient=3, remainder=2.
REQ-034 start held high across DONE -> back-to-back ops, one done pulse per op, 33-cycle spacing between done pulses.
REQ-035 DIVIDER_SIGNED_EN defined: A=-7, B=2 -> quotient=-3, remainder=-1; A=7, B=-2 -> quotient=-3, remainder=1; REQ-028 overflow case checked.
